// File: rtl/writeback_store_forward.sv
// Store-data forwarding responder: watches the writeback retire ports for the
// producer ID a forwarded store waits on, then holds the result until acked.
module writeback_store_forward #(
    parameter int NUM_WB_PORTS = 3,
    parameter int ID_WIDTH     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    gc_issue_flush,
    input  logic [NUM_WB_PORTS-1:0]                 retire_valid,
    input  logic [NUM_WB_PORTS-1:0][ID_WIDTH-1:0]   retire_id,
    input  logic [NUM_WB_PORTS-1:0][31:0]           retire_data,
    input  logic                                    waiting,
    input  logic                                    possibly_waiting,
    input  logic [ID_WIDTH-1:0]                     id_needed,
    input  logic                                    ack,
    output logic                                    id_done,
    output logic [31:0]                             data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [31:0]             data_q;
    logic [NUM_WB_PORTS-1:0] match;
    logic                    hit;
    logic [31:0]             hit_data;
    logic                    arm;
    logic                    capture;

    for (genvar i = 0; i < NUM_WB_PORTS; i++) begin : g_match
        assign match[i] = retire_valid[i] && (retire_id[i] == id_needed);
    end

    // Walk downward so the lowest-index hitting port ends up selected.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = NUM_WB_PORTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_data = retire_data[i];
            end
        end
    end

    // An acked DONE behaves like IDLE, which is what allows back-to-back forwards.
    assign arm     = (state_q == IDLE) || (state_q == DONE && ack);
    assign capture = !gc_issue_flush && hit && possibly_waiting &&
                     (arm || state_q == WAIT);

    always_comb begin
        state_d = state_q;
        if (gc_issue_flush) begin
            state_d = IDLE;
        end else if (arm) begin
            if (waiting) state_d = hit ? DONE : WAIT;
            else         state_d = IDLE;
        end else if (state_q == WAIT && hit) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) data_q <= hit_data;
        end
    end

    assign id_done = (state_q == DONE);
    assign data    = data_q;
endmodule

// File: tb/tb_writeback_store_forward.sv
// Directed bench for writeback_store_forward; expected values are hand-derived.
module tb_writeback_store_forward;
    localparam int NP = 3;
    localparam int IW = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     gc_issue_flush;
    logic [NP-1:0]            retire_valid;
    logic [NP-1:0][IW-1:0]    retire_id;
    logic [NP-1:0][31:0]      retire_data;
    logic                     waiting;
    logic                     possibly_waiting;
    logic [IW-1:0]            id_needed;
    logic                     ack;
    logic                     id_done;
    logic [31:0]              data;

    int vectors = 0;
    int miscompares = 0;

    writeback_store_forward #(.NUM_WB_PORTS(NP), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .gc_issue_flush(gc_issue_flush),
        .retire_valid(retire_valid), .retire_id(retire_id), .retire_data(retire_data),
        .waiting(waiting), .possibly_waiting(possibly_waiting), .id_needed(id_needed),
        .ack(ack), .id_done(id_done), .data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        retire_valid = '0;
        retire_id    = '0;
        retire_data  = '0;
    endtask

    task automatic retire(input int p, input logic [IW-1:0] id, input logic [31:0] d);
        retire_valid[p] = 1'b1;
        retire_id[p]    = id;
        retire_data[p]  = d;
    endtask

    task automatic req(input logic w, input logic [IW-1:0] id);
        waiting          = w;
        possibly_waiting = w;
        id_needed        = id;
    endtask

    initial begin
        // Reset with random inputs
        rst_n            = 1'b0;
        gc_issue_flush   = 1'($urandom);
        retire_valid     = NP'($urandom);
        retire_id        = (NP*IW)'($urandom);
        retire_data      = {$urandom, $urandom, $urandom};
        waiting          = 1'($urandom);
        possibly_waiting = 1'($urandom);
        id_needed        = IW'($urandom);
        ack              = 1'($urandom);
        step(); step();
        chk("rst_done", 32'(id_done), 32'd0);
        chk("rst_data", data, 32'd0);
        gc_issue_flush = 1'b0; ack = 1'b0; quiet(); req(1'b0, '0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_done", 32'(id_done), 32'd0);
        chk("idle_data", data, 32'd0);

        // Wait then retire on port 2
        req(1'b1, 4'd5);
        step();                         // cycle 0 -> WAIT
        chk("wait_done0", 32'(id_done), 32'd0);
        step(); step();                 // cycles 1, 2
        retire(2, 4'd5, 32'hDEADBEEF);
        step();                         // cycle 3 retire
        quiet();
        chk("wr_done4", 32'(id_done), 32'd1);
        chk("wr_data4", data, 32'hDEADBEEF);
        step();                         // cycle 4
        step();                         // cycle 5
        chk("wr_done6", 32'(id_done), 32'd1);
        ack = 1'b1; req(1'b0, 4'd5);
        step();                         // cycle 6 ack
        ack = 1'b0;
        chk("ack_done7", 32'(id_done), 32'd0);
        chk("ack_data7", data, 32'hDEADBEEF);

        // Same-cycle issue and retire
        req(1'b1, 4'd2);
        retire(0, 4'd2, 32'h12345678);
        step();
        quiet();
        chk("same_done", 32'(id_done), 32'd1);
        chk("same_data", data, 32'h12345678);
        ack = 1'b1; req(1'b0, 4'd2);
        step();
        ack = 1'b0;
        chk("same_ack", 32'(id_done), 32'd0);

        // Non-matching retire in WAIT
        req(1'b1, 4'd4);
        step();
        retire(1, 4'd3, 32'h0000FFFF);
        step();
        quiet();
        chk("nomatch_done", 32'(id_done), 32'd0);
        chk("nomatch_data", data, 32'h12345678);

        // Hold in DONE against repeated retires
        retire(1, 4'd4, 32'hA5A5A5A5);
        step();
        chk("hold_done0", 32'(id_done), 32'd1);
        chk("hold_data0", data, 32'hA5A5A5A5);
        retire(1, 4'd4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_done", 32'(id_done), 32'd1);
            chk("hold_data", data, 32'hA5A5A5A5);
        end
        quiet();

        // Back-to-back: ack re-arms with a hit
        ack = 1'b1; req(1'b1, 4'd7);
        retire(1, 4'd7, 32'h00000042);
        step();
        quiet();
        chk("b2b_done", 32'(id_done), 32'd1);
        chk("b2b_data", data, 32'h00000042);
        // Ack re-arms without a hit -> WAIT
        req(1'b1, 4'd9);
        step();
        ack = 1'b0;
        chk("b2b_wait", 32'(id_done), 32'd0);
        chk("b2b_wdata", data, 32'h00000042);

        // Multiple ports hit: lowest index wins
        retire(2, 4'd9, 32'h00000222);
        retire(0, 4'd9, 32'h00000111);
        step();
        quiet();
        chk("prio_done", 32'(id_done), 32'd1);
        chk("prio_data", data, 32'h00000111);
        ack = 1'b1; req(1'b0, 4'd9);
        step();
        ack = 1'b0;

        // Ack outside DONE is ignored
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("stray_ack", 32'(id_done), 32'd0);

        // Flush in WAIT with a concurrent matching retire
        req(1'b1, 4'd6);
        step();
        gc_issue_flush = 1'b1;
        retire(0, 4'd6, 32'h00000BAD);
        step();
        gc_issue_flush = 1'b0; quiet(); req(1'b0, 4'd6);
        chk("fw_done", 32'(id_done), 32'd0);
        chk("fw_data", data, 32'h00000111);
        retire(0, 4'd6, 32'h00000BAD);
        step();
        quiet();
        chk("fw_late", 32'(id_done), 32'd0);

        // Flush in DONE with a concurrent matching retire
        req(1'b1, 4'd8);
        retire(2, 4'd8, 32'h00000088);
        step();
        quiet();
        chk("fd_pre", data, 32'h00000088);
        gc_issue_flush = 1'b1; req(1'b0, 4'd8);
        retire(2, 4'd8, 32'h00000099);
        step();
        gc_issue_flush = 1'b0; quiet();
        chk("fd_done", 32'(id_done), 32'd0);
        chk("fd_data", data, 32'h00000088);
        retire(2, 4'd8, 32'h00000099);
        step();
        quiet();
        chk("fd_late", 32'(id_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
